// File: rtl/taxi_eth_tx_tag_track_if.sv
// AXI-Stream bundle shared by the TX tag tracker ports.
// src drives the payload and valid; snk drives ready.
interface taxi_axis_if #(
  parameter int DATA_W = 8,
  parameter int KEEP_W = 1,
  parameter int ID_W   = 8,
  parameter int USER_W = 1
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [USER_W-1:0] tuser;

  modport src (output tdata, tkeep, tvalid, tlast, tid, tuser, input tready);
  modport snk (input tdata, tkeep, tvalid, tlast, tid, tuser, output tready);
endinterface

// File: rtl/taxi_eth_tx_tag_track.sv
// Tags outgoing frames with a sequential hardware ID, remembers the host ID per tag,
// and maps MAC TX completions (tag + timestamp) back onto the host ID.
module taxi_eth_tx_tag_track #(
  parameter int DEPTH       = 16,
  parameter int ERR_USER_EN = 1
) (
  input  logic          clk,
  input  logic          rst,
  taxi_axis_if.snk      s_axis_tx,
  taxi_axis_if.src      m_axis_tx,
  taxi_axis_if.snk      s_axis_tx_cpl,
  taxi_axis_if.src      m_axis_tx_cpl,
  output logic [$clog2(DEPTH):0] stat_outstanding,
  output logic          err_tag_mismatch,
  output logic          err_unexpected_cpl
);
  localparam int TAG_W      = $clog2(DEPTH);
  localparam int ID_W_H     = s_axis_tx.ID_W;
  localparam int ID_W_M     = m_axis_tx.ID_W;
  localparam int TS_W       = m_axis_tx_cpl.DATA_W;
  localparam int CPL_USER_W = m_axis_tx_cpl.USER_W;

  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [TAG_W:0]    outstanding;
  logic              in_frame;
  logic [ID_W_H-1:0] id_table [DEPTH];

  logic              vld_p1;
  logic [TS_W-1:0]   cpl_data_p1;
  logic [ID_W_H-1:0] cpl_id_p1;
  logic              cpl_err_p1;

  logic go, tx_fire, alloc;
  logic cpl_ready, cpl_fire, retire, unexpected, mismatch;

  // Gate on the registered count only, so completions never reach tx ready combinationally.
  assign go      = in_frame || (outstanding != (TAG_W+1)'(DEPTH));
  assign tx_fire = s_axis_tx.tvalid && s_axis_tx.tready;
  assign alloc   = tx_fire && !in_frame;

  assign m_axis_tx.tvalid = s_axis_tx.tvalid && go;
  assign s_axis_tx.tready = m_axis_tx.tready && go;
  assign m_axis_tx.tdata  = s_axis_tx.tdata;
  assign m_axis_tx.tkeep  = s_axis_tx.tkeep;
  assign m_axis_tx.tlast  = s_axis_tx.tlast;
  assign m_axis_tx.tuser  = s_axis_tx.tuser;
  assign m_axis_tx.tid    = ID_W_M'(head);

  assign cpl_ready  = !vld_p1 || m_axis_tx_cpl.tready;
  assign cpl_fire   = s_axis_tx_cpl.tvalid && cpl_ready;
  assign retire     = cpl_fire && (outstanding != '0);
  assign unexpected = cpl_fire && (outstanding == '0);
  assign mismatch   = retire && (s_axis_tx_cpl.tid[TAG_W-1:0] != tail);

  assign s_axis_tx_cpl.tready = cpl_ready;

  always_ff @(posedge clk) begin
    if (alloc) begin
      id_table[head] <= s_axis_tx.tid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head               <= '0;
      tail               <= '0;
      outstanding        <= '0;
      in_frame           <= 1'b0;
      err_tag_mismatch   <= 1'b0;
      err_unexpected_cpl <= 1'b0;
    end else begin
      if (tx_fire) begin
        in_frame <= !s_axis_tx.tlast;
        if (s_axis_tx.tlast) begin
          head <= head + 1'b1;
        end
      end
      if (retire) begin
        tail <= tail + 1'b1;
      end
      case ({alloc, retire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      err_tag_mismatch   <= mismatch;
      err_unexpected_cpl <= unexpected;
    end
  end

  // Completion output stage: a mismatched tag still retires the tail entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      cpl_data_p1 <= '0;
      cpl_id_p1   <= '0;
      cpl_err_p1  <= 1'b0;
    end else if (retire) begin
      vld_p1      <= 1'b1;
      cpl_data_p1 <= s_axis_tx_cpl.tdata;
      cpl_id_p1   <= id_table[tail];
      cpl_err_p1  <= mismatch;
    end else if (m_axis_tx_cpl.tready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign m_axis_tx_cpl.tvalid = vld_p1;
  assign m_axis_tx_cpl.tdata  = cpl_data_p1;
  assign m_axis_tx_cpl.tid    = cpl_id_p1;
  assign m_axis_tx_cpl.tkeep  = '1;
  assign m_axis_tx_cpl.tlast  = 1'b1;
  assign m_axis_tx_cpl.tuser  = (ERR_USER_EN != 0) ? CPL_USER_W'(cpl_err_p1) : '0;

  assign stat_outstanding = outstanding;

  wire unused_cpl = ^{s_axis_tx_cpl.tkeep, s_axis_tx_cpl.tlast, s_axis_tx_cpl.tuser,
                      s_axis_tx_cpl.tid};
endmodule

// File: tb/tb_taxi_eth_tx_tag_track.sv
// Directed bench for the TX tag tracker: tagging, full stall/wrap, completion mapping,
// error pulses, output backpressure, simultaneous allocate/retire and mid-frame reset.
module tb_taxi_eth_tx_tag_track;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] stat_outstanding;
  logic err_tag_mismatch;
  logic err_unexpected_cpl;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  taxi_axis_if #(.DATA_W(16), .KEEP_W(2), .ID_W(8), .USER_W(1)) tx_in ();
  taxi_axis_if #(.DATA_W(16), .KEEP_W(2), .ID_W(8), .USER_W(1)) tx_out ();
  taxi_axis_if #(.DATA_W(16), .KEEP_W(2), .ID_W(8), .USER_W(1)) cpl_in ();
  taxi_axis_if #(.DATA_W(16), .KEEP_W(2), .ID_W(8), .USER_W(1)) cpl_out ();

  taxi_eth_tx_tag_track #(.DEPTH(16), .ERR_USER_EN(1)) dut (
    .clk                (clk),
    .rst                (rst),
    .s_axis_tx          (tx_in),
    .m_axis_tx          (tx_out),
    .s_axis_tx_cpl      (cpl_in),
    .m_axis_tx_cpl      (cpl_out),
    .stat_outstanding   (stat_outstanding),
    .err_tag_mismatch   (err_tag_mismatch),
    .err_unexpected_cpl (err_unexpected_cpl)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tx_in.tvalid = 1'b0;
    cpl_in.tvalid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] id, input logic last, input logic [7:0] exp_tag);
    tx_in.tvalid = 1'b1;
    tx_in.tid    = id;
    tx_in.tlast  = last;
    tx_in.tdata  = {id, 8'hC3};
    #2;
    check("tx_valid", tx_out.tvalid, 1);
    check("tx_ready", tx_in.tready, 1);
    check("tx_tag", tx_out.tid, exp_tag);
    check("tx_data", tx_out.tdata, {id, 8'hC3});
    tick();
    tx_in.tvalid = 1'b0;
  endtask

  task automatic send_cpl(input logic [7:0] tag, input logic [15:0] ts);
    cpl_in.tvalid = 1'b1;
    cpl_in.tid    = tag;
    cpl_in.tdata  = ts;
    tick();
    cpl_in.tvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tx_in.tvalid = 1'b0; tx_in.tdata = '0; tx_in.tkeep = 2'b11; tx_in.tlast = 1'b0;
    tx_in.tid = '0; tx_in.tuser = '0;
    cpl_in.tvalid = 1'b0; cpl_in.tdata = '0; cpl_in.tkeep = 2'b11; cpl_in.tlast = 1'b1;
    cpl_in.tid = '0; cpl_in.tuser = '0;
    tx_out.tready = 1'b1;
    cpl_out.tready = 1'b1;
    do_reset();
    #2;
    check("rst_stat", stat_outstanding, 0);
    check("rst_cpl_valid", cpl_out.tvalid, 0);
    check("rst_err_mm", err_tag_mismatch, 0);
    check("rst_err_unexp", err_unexpected_cpl, 0);

    // Single 3-beat frame, host id 0x5A, completion ts 0x1234
    tick();
    send_beat(8'h5A, 1'b0, 8'h00);
    send_beat(8'h5A, 1'b0, 8'h00);
    send_beat(8'h5A, 1'b1, 8'h00);
    #2;
    check("t1_stat", stat_outstanding, 1);
    tick();
    send_cpl(8'h00, 16'h1234);
    #2;
    check("t1_cpl_valid", cpl_out.tvalid, 1);
    check("t1_cpl_tid", cpl_out.tid, 8'h5A);
    check("t1_cpl_ts", cpl_out.tdata, 16'h1234);
    check("t1_cpl_user", cpl_out.tuser, 0);
    check("t1_stat0", stat_outstanding, 0);
    tick();
    #2;
    check("t1_cpl_drained", cpl_out.tvalid, 0);

    // Fill to DEPTH, 17th frame stalls until one completion retires tag 0
    do_reset();
    for (int i = 0; i < 16; i++) send_beat(8'h10 + 8'(i), 1'b1, 8'(i));
    tx_in.tvalid = 1'b1; tx_in.tid = 8'h2F; tx_in.tlast = 1'b1;
    cpl_in.tvalid = 1'b1; cpl_in.tid = 8'h00; cpl_in.tdata = 16'h0099;
    #2;
    check("full_stat", stat_outstanding, 16);
    check("full_tready", tx_in.tready, 0);
    check("full_tvalid", tx_out.tvalid, 0);
    check("full_cpl_ready", cpl_in.tready, 1);
    tick();
    cpl_in.tvalid = 1'b0;
    #2;
    check("wrap_stat", stat_outstanding, 15);
    check("wrap_tready", tx_in.tready, 1);
    check("wrap_tag", tx_out.tid, 0);
    check("wrap_cpl_tid", cpl_out.tid, 8'h10);
    tick();
    tx_in.tvalid = 1'b0;
    #2;
    check("wrap_stat_after", stat_outstanding, 16);

    // Completion with nothing outstanding
    do_reset();
    send_cpl(8'h03, 16'h0555);
    #2;
    check("unexp_pulse", err_unexpected_cpl, 1);
    check("unexp_no_out", cpl_out.tvalid, 0);
    check("unexp_stat", stat_outstanding, 0);
    check("unexp_no_mm", err_tag_mismatch, 0);
    tick();
    #2;
    check("unexp_pulse_end", err_unexpected_cpl, 0);

    // Tag mismatch still retires the tail
    do_reset();
    send_beat(8'h07, 1'b1, 8'h00);
    send_beat(8'h09, 1'b1, 8'h01);
    send_cpl(8'h01, 16'h0AAA);
    #2;
    check("mm_pulse", err_tag_mismatch, 1);
    check("mm_tid", cpl_out.tid, 8'h07);
    check("mm_user", cpl_out.tuser, 1);
    check("mm_stat", stat_outstanding, 1);
    tick();
    send_cpl(8'h01, 16'h0BBB);
    #2;
    check("mm_next_err", err_tag_mismatch, 0);
    check("mm_next_tid", cpl_out.tid, 8'h09);
    check("mm_next_user", cpl_out.tuser, 0);
    check("mm_next_stat", stat_outstanding, 0);

    // Output backpressure with three completions queued
    do_reset();
    send_beat(8'hA1, 1'b1, 8'h00);
    send_beat(8'hA2, 1'b1, 8'h01);
    send_beat(8'hA3, 1'b1, 8'h02);
    cpl_out.tready = 1'b0;
    send_cpl(8'h00, 16'h0100);
    cpl_in.tvalid = 1'b1; cpl_in.tid = 8'h01; cpl_in.tdata = 16'h0101;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("bp_cpl_ready", cpl_in.tready, 0);
      check("bp_hold_tid", cpl_out.tid, 8'hA1);
      check("bp_hold_valid", cpl_out.tvalid, 1);
      tick();
    end
    cpl_out.tready = 1'b1;
    #2;
    check("bp_release_ready", cpl_in.tready, 1);
    check("bp_out0_ts", cpl_out.tdata, 16'h0100);
    tick();
    cpl_in.tid = 8'h02; cpl_in.tdata = 16'h0102;
    #2;
    check("bp_out1_valid", cpl_out.tvalid, 1);
    check("bp_out1_tid", cpl_out.tid, 8'hA2);
    check("bp_out1_ts", cpl_out.tdata, 16'h0101);
    tick();
    cpl_in.tvalid = 1'b0;
    #2;
    check("bp_out2_tid", cpl_out.tid, 8'hA3);
    check("bp_out2_ts", cpl_out.tdata, 16'h0102);
    tick();
    #2;
    check("bp_drained", cpl_out.tvalid, 0);
    check("bp_stat", stat_outstanding, 0);
    check("bp_no_mm", err_tag_mismatch, 0);

    // Allocate and retire together at outstanding=4, then reset mid-frame
    do_reset();
    for (int i = 0; i < 4; i++) send_beat(8'h31 + 8'(i), 1'b1, 8'(i));
    cpl_in.tvalid = 1'b1; cpl_in.tid = 8'h00; cpl_in.tdata = 16'h0400;
    send_beat(8'h35, 1'b0, 8'h04);
    cpl_in.tvalid = 1'b0;
    #2;
    check("sim_stat", stat_outstanding, 4);
    check("sim_cpl_tid", cpl_out.tid, 8'h31);
    tick();
    send_beat(8'h35, 1'b1, 8'h04);
    send_cpl(8'h01, 16'h0401);
    #2;
    check("sim_tail_tid", cpl_out.tid, 8'h32);
    check("sim_tail_err", err_tag_mismatch, 0);
    check("sim_tail_stat", stat_outstanding, 3);
    tick();
    send_beat(8'h40, 1'b0, 8'h05);
    do_reset();
    #2;
    check("mid_rst_stat", stat_outstanding, 0);
    check("mid_rst_cpl_valid", cpl_out.tvalid, 0);
    check("mid_rst_tx_valid", tx_out.tvalid, 0);
    check("mid_rst_err", {err_tag_mismatch, err_unexpected_cpl}, 0);
    tick();
    send_beat(8'h41, 1'b1, 8'h00);
    #2;
    check("mid_rst_first_beat", stat_outstanding, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
